// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one system bus between two masters, m0 (CPU/control) and m1
//   (video-update/DMA). Arbitration is round-robin with a req/gnt handshake.
//   A tenure is limited to BURST_MAX transfers, but only when the other
//   master is waiting.
//
// Handshake: a master raises mX_req and holds it for the whole burst.
//   mX_gnt rises one cycle after the arbiter samples the request in IDLE.
//   A transfer happens in every cycle where mX_gnt and mX_req are both high.
//   Dropping mX_req ends the tenure; gnt falls on the next cycle.
//   Every handover passes through at least one IDLE cycle with both gnt low.
//
// Optional feature (macro ARB_VSYNC_PRIO_EN):
//   While vsync=1, m1 wins any IDLE tie.
//   Its tenure also ignores BURST_MAX.
//   Without the macro, vsync is ignored.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   vsync           vertical-sync flag from the LCD timing block
//   m0_*/m1_*       req, addr, wdata, rw (1=write) in; gnt, rdata, rvalid out
//   bus_addr/data   address and write data to the decoder (0 when no transfer)
//   bus_rw          write strobe to the peripherals
//   bus_din         read data from the decoder
//   bus_owner       0 = m0, 1 = m1 (meaningful while a gnt is high)
//   state_dbg       current arbiter state (IDLE=0, OWN0=1, OWN1=2)
module bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rw,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rw,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_data,
  output logic          bus_rw,
  input  logic [DW-1:0] bus_din,
  output logic          bus_owner,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int            CW   = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);

  state_t        state, state_next;
  logic          rr_last, rr_last_next;   // last owner; the other master wins a tie
  logic [CW-1:0] burst_cnt, cnt_next, cnt_inc;
  logic          xfer0, xfer1;
  logic          vsync_prio;

`ifdef ARB_VSYNC_PRIO_EN
  assign vsync_prio = vsync;
`else
  logic unused_vsync;
  assign vsync_prio   = 1'b0;
  assign unused_vsync = vsync;
`endif

  // A transfer needs both the grant and a still-asserted request.
  // If req drops while gnt is high, the bus stays quiet.
  assign xfer0 = (state == OWN0) && m0_req;
  assign xfer1 = (state == OWN1) && m1_req;

  // Burst counter value after this cycle's transfer, saturating at BURST_MAX.
  assign cnt_inc = (burst_cnt == BMAX) ? BMAX : burst_cnt + CW'(1);

  always_comb begin
    state_next   = state;
    rr_last_next = rr_last;
    cnt_next     = burst_cnt;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_next = (vsync_prio || !rr_last) ? OWN1 : OWN0;
        end else if (m0_req) begin
          state_next = OWN0;
        end else if (m1_req) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req || (cnt_inc == BMAX && m1_req)) begin
          state_next   = IDLE;
          rr_last_next = 1'b0;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      OWN1: begin
        // Under vsync priority, only m1 dropping its request ends the tenure.
        if (!m1_req || (cnt_inc == BMAX && m0_req && !vsync_prio)) begin
          state_next   = IDLE;
          rr_last_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      rr_last   <= rr_last_next;
      burst_cnt <= cnt_next;
    end
  end

  // Read data is captured on the transfer edge and presented for one cycle.
  // rdata keeps its last value between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= xfer0 && !m0_rw;
      m1_rvalid <= xfer1 && !m1_rw;
      if (xfer0 && !m0_rw) m0_rdata <= bus_din;
      if (xfer1 && !m1_rw) m1_rdata <= bus_din;
    end
  end

  always_comb begin
    bus_addr = '0;
    bus_data = '0;
    bus_rw   = 1'b0;
    if (xfer0) begin
      bus_addr = m0_addr;
      bus_data = m0_wdata;
      bus_rw   = m0_rw;
    end else if (xfer1) begin
      bus_addr = m1_addr;
      bus_data = m1_wdata;
      bus_rw   = m1_rw;
    end
  end

  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign bus_owner = (state == OWN1);
  assign state_dbg = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed scenarios (write, read, burst handover, long solo burst, vsync
//   priority, mid-burst reset) followed by randomized traffic.
//   All outputs are compared against a tenure-level reference model.
//   The model tracks the current owner, the previous owner and the transfer
//   count. Read data goes through an expected queue.
module tb_bus_arbiter;
  localparam int AW        = 16;
  localparam int DW        = 8;
  localparam int BURST_MAX = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          vsync;
  logic          m0_req, m0_rw, m1_req, m1_rw;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, bus_din;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_rw, bus_owner;
  logic [DW-1:0] m0_rdata, m1_rdata, bus_data;
  logic [AW-1:0] bus_addr;
  logic [1:0]    state_dbg;

  bus_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw), .bus_din(bus_din),
    .bus_owner(bus_owner), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (-1 none), who owned it last, and
  // how many transfers the current tenure has made.
  int            m_own;
  int            m_last;
  int            m_cnt;
  bit            m_rv[2];
  logic [DW-1:0] m_rd[2];
  logic [DW:0]   exp_q[$];   // {master, read data}

  // Values sampled at the last negedge, for scenario-level counting.
  logic          g0_s, g1_s, rw_s, rv0_s;
  logic [AW-1:0] a_s;
  logic [DW-1:0] d_s, rd0_s;

  task automatic model_reset();
    m_own  = -1;
    m_last = 1;
    m_cnt  = 0;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    bit x0, x1, vp, mine, other;
    vp = 1'b0;
`ifdef ARB_VSYNC_PRIO_EN
    vp = vsync;
`endif
    x0 = (m_own == 0) && m0_req;
    x1 = (m_own == 1) && m1_req;
    m_rv[0] = x0 && !m0_rw;
    m_rv[1] = x1 && !m1_rw;
    if (m_rv[0]) begin
      m_rd[0] = bus_din;
      exp_q.push_back({1'b0, bus_din});
    end
    if (m_rv[1]) begin
      m_rd[1] = bus_din;
      exp_q.push_back({1'b1, bus_din});
    end
    if (m_own < 0) begin
      if (m0_req && m1_req) m_own = (vp || m_last == 0) ? 1 : 0;
      else if (m0_req)      m_own = 0;
      else if (m1_req)      m_own = 1;
    end else begin
      mine  = (m_own == 0) ? m0_req : m1_req;
      other = (m_own == 0) ? m1_req : m0_req;
      if (!mine) begin
        m_last = m_own; m_cnt = 0; m_own = -1;
      end else begin
        if (m_cnt < BURST_MAX) m_cnt++;
        if (m_cnt == BURST_MAX && other && !(m_own == 1 && vp)) begin
          m_last = m_own; m_cnt = 0; m_own = -1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit            x0, x1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erw;
    logic [DW:0]   ent;
    x0 = (m_own == 0) && m0_req;
    x1 = (m_own == 1) && m1_req;
    ea = '0; ed = '0; erw = 1'b0;
    if (x0) begin ea = m0_addr; ed = m0_wdata; erw = m0_rw; end
    if (x1) begin ea = m1_addr; ed = m1_wdata; erw = m1_rw; end
    check_eq("gnt0", 32'(m0_gnt), 32'(m_own == 0));
    check_eq("gnt1", 32'(m1_gnt), 32'(m_own == 1));
    if (m_own >= 0) check_eq("owner", 32'(bus_owner), 32'(m_own == 1));
    check_eq("bus_addr", 32'(bus_addr), 32'(ea));
    check_eq("bus_data", 32'(bus_data), 32'(ed));
    check_eq("bus_rw", 32'(bus_rw), 32'(erw));
    check_eq("rvalid0", 32'(m0_rvalid), 32'(m_rv[0]));
    check_eq("rvalid1", 32'(m1_rvalid), 32'(m_rv[1]));
    check_eq("rdata0", 32'(m0_rdata), 32'(m_rd[0]));
    check_eq("rdata1", 32'(m1_rdata), 32'(m_rd[1]));
    for (int m = 0; m < 2; m++) begin
      if (m_rv[m]) begin
        if (exp_q.size() == 0) begin
          check_eq("read_q", 32'(exp_q.size()), 32'd1);
        end else begin
          ent = exp_q.pop_front();
          check_eq("read_q_src", 32'(ent[DW]), 32'(m));
          check_eq("read_q_data", 32'(m == 0 ? m0_rdata : m1_rdata), 32'(ent[DW-1:0]));
        end
      end
    end
    g0_s = m0_gnt; g1_s = m1_gnt; rw_s = bus_rw; a_s = bus_addr;
    d_s = bus_data; rv0_s = m0_rvalid; rd0_s = m0_rdata;
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; outputs are checked at the negedge;
  // the model advances on the posedge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    if (!reset) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (!v) model_reset();
  endtask

  task automatic idle_inputs();
    vsync = 1'b0;
    m0_req = 1'b0; m0_rw = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_rw = 1'b0; m1_addr = '0; m1_wdata = '0;
    bus_din = '0;
  endtask

  task automatic restart();
    set_reset(1'b0);
    idle_inputs();
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int m0_xfers, dead, rw_cnt, drops, g1_run;
    bit seen_g0, seen_g1, prev_g0;

    idle_inputs();
    set_reset(1'b0);
    repeat (3) cycle();

    // Single m0 write.
    set_reset(1'b1);
    m0_req = 1'b1; m0_addr = 16'hF005; m0_wdata = 8'h41; m0_rw = 1'b1;
    cycle();
    cycle();
    check_eq("t2_gnt0", 32'(g0_s), 32'd1);
    check_eq("t2_addr", 32'(a_s), 32'hF005);
    check_eq("t2_data", 32'(d_s), 32'h41);
    check_eq("t2_rw", 32'(rw_s), 32'd1);

    // Reset while m0 is mid-burst.
    repeat (2) cycle();
    set_reset(1'b0);
    cycle();
    check_eq("t1_gnt0", 32'(g0_s), 32'd0);
    check_eq("t1_gnt1", 32'(g1_s), 32'd0);
    check_eq("t1_rw", 32'(rw_s), 32'd0);
    check_eq("t1_addr", 32'(a_s), 32'd0);
    check_eq("t1_rvalid", 32'(rv0_s), 32'd0);

    // Single m0 read.
    idle_inputs();
    set_reset(1'b1);
    m0_req = 1'b1; m0_rw = 1'b0; m0_addr = 16'h0000; bus_din = 8'h5A;
    cycle();
    cycle();
    m0_req = 1'b0; bus_din = 8'h00;
    cycle();
    check_eq("t3_rvalid", 32'(rv0_s), 32'd1);
    check_eq("t3_rdata", 32'(rd0_s), 32'h5A);
    cycle();
    check_eq("t3_rvalid_end", 32'(rv0_s), 32'd0);
    check_eq("t3_rdata_hold", 32'(rd0_s), 32'h5A);

    // Both masters request from reset: m0 bursts, one dead cycle, then m1.
    restart();
    m0_req = 1'b1; m0_rw = 1'b1; m1_req = 1'b1; m1_rw = 1'b1;
    m0_addr = 16'h1234; m1_addr = 16'h5678;
    set_reset(1'b1);
    m0_xfers = 0; dead = 0; seen_g0 = 1'b0; seen_g1 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (!seen_g1) begin
        if (g1_s) seen_g1 = 1'b1;
        else if (g0_s) begin
          seen_g0 = 1'b1;
          if (rw_s) m0_xfers++;
        end else if (seen_g0) dead++;
      end
    end
    check_eq("t4_m0_xfers", 32'(m0_xfers), 32'(BURST_MAX));
    check_eq("t4_dead", 32'(dead), 32'd1);
    check_eq("t4_m1_granted", 32'(seen_g1), 32'd1);

    // m0 alone: 20 writes with no break in the grant.
    restart();
    m0_req = 1'b1; m0_rw = 1'b1;
    set_reset(1'b1);
    rw_cnt = 0; drops = 0; prev_g0 = 1'b0;
    for (int i = 0; i < 21; i++) begin
      m0_addr = 16'($urandom_range(0, 65535));
      m0_wdata = 8'($urandom_range(0, 255));
      cycle();
      if (g0_s && rw_s) rw_cnt++;
      if (prev_g0 && !g0_s) drops++;
      prev_g0 = g0_s;
    end
    check_eq("t5_writes", 32'(rw_cnt), 32'd20);
    check_eq("t5_drops", 32'(drops), 32'd0);

    // vsync with both masters requesting.
    restart();
    vsync = 1'b1;
    m0_req = 1'b1; m0_rw = 1'b1; m1_req = 1'b1; m1_rw = 1'b1;
    set_reset(1'b1);
    cycle();
    cycle();
`ifdef ARB_VSYNC_PRIO_EN
    check_eq("t6_first_m1", 32'(g1_s), 32'd1);
    g1_run = 1;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (g1_s && rw_s) g1_run++;
    end
    check_eq("t6_m1_run", 32'(g1_run), 32'd20);
`else
    check_eq("t6_first_m0", 32'(g0_s), 32'd1);
    g1_run = 0;
    for (int i = 0; i < 19; i++) begin
      cycle();
      if (g1_s) g1_run++;
    end
    check_eq("t6_m1_after_handover", 32'(g1_run > 0), 32'd1);
`endif
    vsync = 1'b0;

    // Randomized traffic with sticky requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 15) == 0) vsync = ~vsync;
      m0_rw = 1'($urandom_range(0, 1));
      m1_rw = 1'($urandom_range(0, 1));
      m0_addr = 16'($urandom_range(0, 65535));
      m1_addr = 16'($urandom_range(0, 65535));
      m0_wdata = 8'($urandom_range(0, 255));
      m1_wdata = 8'($urandom_range(0, 255));
      bus_din = 8'($urandom_range(0, 255));
      if (!reset) set_reset(1'b1);
      else if ($urandom_range(0, 299) == 0) set_reset(1'b0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
